// File: rtl/mem_stream_ctrl.sv
// Single-port memory with a CPU port and a command-driven block load/dump engine; dump is built only with MEM_DUMP_EN.
// Latency: CPU read 1 cycle; load 1 word/cycle; dump 1 word per 2 cycles; done pulses 1 cycle after the last word.
// Backpressure: ld_valid low or dp_ready low stalls the engine losslessly; the CPU port is ignored (cpu_stall) while busy.
module mem_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 65536
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_stall,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  dp_valid,
    input  logic                  dp_ready,
    output logic [DATA_WIDTH-1:0] dp_data,
    output logic                  busy,
    output logic                  done
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_DUMP_EN
    typedef enum logic [2:0] {IDLE, LOAD, DUMP_RD, DUMP_OUT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q, len_q, count_q;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic                  cmd_fire, ld_fire, step;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we, mem_hit;
    logic [DATA_WIDTH-1:0] mem_wdat, mem_rdat;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    // Address wraps naturally at 2^ADDR_WIDTH.
    assign eng_addr  = base_q + count_q;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign cpu_stall = busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        ld_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
`ifdef MEM_DUMP_EN
        dp_valid  = 1'b0;
`endif
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = reset_n;
                if (cmd_valid && reset_n) begin
                    if (cmd_len == '0) begin
                        state_nxt = DONE;
                    end else if (cmd_mode) begin
`ifdef MEM_DUMP_EN
                        state_nxt = DUMP_RD;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                ld_ready = reset_n;
                if (ld_valid && reset_n && (count_q + ADDR_WIDTH'(1) == len_q)) begin
                    state_nxt = DONE;
                end
            end
`ifdef MEM_DUMP_EN
            DUMP_RD: begin
                state_nxt = DUMP_OUT;
            end
            DUMP_OUT: begin
                dp_valid = 1'b1;
                if (dp_ready) begin
                    state_nxt = (count_q + ADDR_WIDTH'(1) == len_q) ? DONE : DUMP_RD;
                end
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef MEM_DUMP_EN
    assign step = ld_fire || (dp_valid && dp_ready);
`else
    logic unused_dp_ready;
    assign unused_dp_ready = dp_ready;
    assign step            = ld_fire;
    assign dp_valid        = 1'b0;
    assign dp_data         = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else if (cmd_fire) begin
            base_q  <= cmd_base;
            len_q   <= cmd_len;
            count_q <= '0;
        end else if (step) begin
            count_q <= count_q + ADDR_WIDTH'(1);
        end
    end

    // One shared array port: the CPU owns it in IDLE, the engine otherwise.
    always_comb begin
        mem_addr = cpu_addr;
        mem_wdat = cpu_din;
        mem_we   = cpu_we && !busy && reset_n;
        if (ld_fire) begin
            mem_addr = eng_addr;
            mem_wdat = ld_data;
            mem_we   = 1'b1;
        end
`ifdef MEM_DUMP_EN
        if (state == DUMP_RD) begin
            mem_addr = eng_addr;
        end
`endif
    end

    assign mem_hit  = in_range(mem_addr);
    assign mem_rdat = mem_hit ? mem[mem_addr[IDX_W-1:0]] : '0;

    // Array is deliberately left out of reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we && mem_hit) begin
            mem[mem_addr[IDX_W-1:0]] <= mem_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_dout <= '0;
        end else if (!busy && !cpu_we) begin
            cpu_dout <= mem_rdat;
        end
    end

`ifdef MEM_DUMP_EN
    logic [DATA_WIDTH-1:0] dp_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dp_data_q <= '0;
        end else if (state == DUMP_RD) begin
            dp_data_q <= mem_rdat;
        end
    end

    assign dp_data = dp_data_q;
`endif

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Randomized bench for mem_stream_ctrl with a flat memory model indexed by address.
module tb_mem_stream_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 32'h8000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_din = '0;
    logic [DW-1:0] cpu_dout;
    logic          cpu_stall;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_mode = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          dp_valid;
    logic          dp_ready = 1'b0;
    logic [DW-1:0] dp_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mem_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data),
        .busy(busy), .done(done)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] model [65536];
    bit         known [65536];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mwrite(input logic [15:0] a, input logic [7:0] d);
        if (int'(a) < DEPTH) begin
            model[a] = d;
            known[a] = 1'b1;
        end
    endfunction

    function automatic logic [7:0] mexp(input logic [15:0] a);
        return (int'(a) < DEPTH) ? model[a] : 8'h00;
    endfunction

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        mwrite(a, d);
    endtask

    task automatic cpu_rd_chk(input string tag, input logic [15:0] a);
        cpu_addr = a; cpu_we = 1'b0;
        tick();
        if (int'(a) >= DEPTH || known[a]) chk(tag, cpu_dout, mexp(a));
    endtask

    task automatic issue(input logic mode, input logic [15:0] base, input logic [15:0] len);
        cmd_mode = mode; cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cpu_we    = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    // vmode: 0 continuous, 1 toggling, 2 random ld_valid
    task automatic run_load(input logic [15:0] base, input int len, input int vmode, input bit fixed,
                            input bit poke, output int done_cyc, output int n_done);
        int acc, cyc;
        bit took;
        logic [7:0] w;
        issue(1'b0, base, 16'(len));
        acc = 0; cyc = 1; done_cyc = -1; n_done = 0;
        while (busy && cyc < 400) begin
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (len == 0) chk("len0_no_ld_ready", ld_ready, 0);
            case (vmode)
                0:       ld_valid = acc < len;
                1:       ld_valid = (acc < len) && cyc[0];
                default: ld_valid = (acc < len) && ($urandom_range(0, 1) == 1);
            endcase
            ld_data = fixed ? 8'((acc + 1) * 17) : 8'($urandom);
            if (poke && cyc == 1) begin
                cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_din = 8'hEE;
                chk("cpu_stall_load", cpu_stall, 1);
            end
            took = ld_valid && ld_ready;
            w    = ld_data;
            tick();
            cyc++;
            cpu_we   = 1'b0;
            ld_valid = 1'b0;
            if (took) begin
                mwrite(base + 16'(acc), w);
                acc++;
            end
        end
        chk("load_end_busy", busy, 0);
        chk("load_words", acc, len);
    endtask

    task automatic run_dump(input logic [15:0] base, input int len, input int stall_word, input int stall_n,
                            input bit rnd, output int done_cyc, output int n_done, output int first_v,
                            output int got);
        int cyc, stalls;
        bit held, took;
        logic [7:0] prev;
        issue(1'b1, base, 16'(len));
        got = 0; cyc = 1; stalls = 0; held = 1'b0; prev = '0;
        first_v = -1; done_cyc = -1; n_done = 0;
        while (busy && cyc < 400) begin
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (dp_valid) begin
                if (first_v < 0) first_v = cyc;
                if (held) chk("dp_hold", dp_data, prev);
                if (got == stall_word && stalls < stall_n) begin
                    dp_ready = 1'b0;
                    stalls++;
                end else begin
                    dp_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
            end else begin
                dp_ready = ($urandom_range(0, 1) == 1);
            end
            took = dp_valid && dp_ready;
            if (took) begin
                chk("dp_data", dp_data, mexp(base + 16'(got)));
                got++;
            end
            held = dp_valid && !dp_ready;
            prev = dp_data;
            tick();
            cyc++;
        end
        dp_ready = 1'b0;
        chk("dump_end_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nd, fv, gw, len;
        logic [15:0] a, base;
        logic [15:0] wr_q[$];

        repeat (3) tick();
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_dp_data", dp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        cpu_wr(16'h0010, 8'hA5);
        cpu_addr = 16'h0010;
        tick();
        chk("cpu_rd_a5", cpu_dout, 8'hA5);

        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            if (i % 2 == 0) a[15] = 1'b0;
            cpu_wr(a, 8'($urandom));
            wr_q.push_back(a);
        end
        foreach (wr_q[i]) cpu_rd_chk("cpu_rand_rd", wr_q[i]);

        // Load with a CPU write on the handshake cycle and a blocked one mid-transfer
        cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_din = 8'h5A;
        mwrite(16'h0300, 8'h5A);
        run_load(16'h0200, 4, 1, 1'b1, 1'b1, dc, nd);
        chk("load_done_once", nd, 1);
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'h0200 + 16'(i);
            tick();
            chk("load_0200", cpu_dout, 8'((i + 1) * 17));
        end
        cpu_rd_chk("cpu_hs_write_0300", 16'h0300);

        run_load(16'h1000, 5, 0, 1'b0, 1'b0, dc, nd);
        chk("load_done_cycle", dc, 6);
        chk("load_done_once_c", nd, 1);

`ifdef MEM_DUMP_EN
        run_dump(16'h0200, 4, 1, 3, 1'b0, dc, nd, fv, gw);
        chk("dump_first_valid", fv, 2);
        chk("dump_words", gw, 4);
        chk("dump_done_once", nd, 1);
        run_dump(16'h1000, 5, -1, 0, 1'b0, dc, nd, fv, gw);
        chk("dump_done_cycle", dc, 11);
        chk("dump_words_c", gw, 5);
`else
        run_dump(16'h0200, 4, 1, 3, 1'b0, dc, nd, fv, gw);
        chk("nodump_no_valid", fv, -1);
        chk("nodump_words", gw, 0);
        chk("nodump_done_cycle", dc, 1);
        chk("nodump_done_once", nd, 1);
`endif

        // Wrap past 0xFFFF through the unimplemented upper half
        run_load(16'hFFFE, 4, 2, 1'b0, 1'b0, dc, nd);
        chk("wrap_done_once", nd, 1);
        cpu_rd_chk("wrap_rd_fffe", 16'hFFFE);
        cpu_rd_chk("wrap_rd_ffff", 16'hFFFF);
        cpu_rd_chk("wrap_rd_0000", 16'h0000);
        cpu_rd_chk("wrap_rd_0001", 16'h0001);

        run_load(16'h0500, 0, 0, 1'b0, 1'b0, dc, nd);
        chk("len0_done_cycle", dc, 1);
        chk("len0_done_once", nd, 1);

        // Reset mid-load
        cpu_wr(16'h0402, 8'h77);
        issue(1'b0, 16'h0400, 16'd4);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 8'hC0 + 8'(i);
            chk("mid_ld_ready", ld_ready, 1);
            tick();
            mwrite(16'h0400 + 16'(i), 8'hC0 + 8'(i));
        end
        ld_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ld_ready", ld_ready, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_cpu_stall", cpu_stall, 0);
        tick();
        chk("abort_done2", done, 0);
        reset_n = 1'b1;
        #1;
        chk("abort_rel_cmd_ready", cmd_ready, 1);
        cpu_rd_chk("abort_keep_0400", 16'h0400);
        cpu_rd_chk("abort_keep_0401", 16'h0401);
        cpu_rd_chk("abort_keep_0402", 16'h0402);

        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0:       base = 16'h7FFC;
                1:       base = 16'hFFFC;
                default: base = 16'($urandom_range(0, 32'h7FF0));
            endcase
            len = $urandom_range(1, 6);
            run_load(base, len, 2, 1'b0, 1'b0, dc, nd);
            chk("rnd_load_done", nd, 1);
            for (int i = 0; i < len; i++) cpu_rd_chk("rnd_rd", base + 16'(i));
`ifdef MEM_DUMP_EN
            run_dump(base, len, 0, $urandom_range(0, 3), 1'b1, dc, nd, fv, gw);
            chk("rnd_dump_words", gw, len);
            chk("rnd_dump_done", nd, 1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stream_ctrl.md
# mem_stream_ctrl

Parametrised single-port system memory with a built-in bulk transfer engine. It replaces the bus-wide override and monitor arrays used for bench preloading with a streaming load/dump interface. The CPU side keeps the write-enable/address/data protocol of the existing memory and sits on the cpu_top A/D bus. A command-driven engine moves contiguous blocks in or out over valid/ready streams, so benches and a future boot loader can fill or inspect memory without hierarchical access.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 16, address width in bits
- DEPTH, 65536, number of implemented words; must be ≤ 2^ADDR_WIDTH
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_we  in  1  CPU write enable (inverse of R_W_n)
- cpu_din  in  DATA_WIDTH  CPU write data
- cpu_dout  out  DATA_WIDTH  registered CPU read data
- cpu_stall  out  1  high while the engine owns the array
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_mode  in  1  0 = load, 1 = dump
- cmd_base  in  ADDR_WIDTH  first address of the block
- cmd_len  in  ADDR_WIDTH  number of words to transfer
- ld_valid / ld_ready  in / out  1  load stream handshake
- ld_data  in  DATA_WIDTH  load word
- dp_valid / dp_ready  out / in  1  dump stream handshake
- dp_data  out  DATA_WIDTH  dump word
- busy  out  1  engine active
- done  out  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD, DUMP_RD, DUMP_OUT, DONE.
- IDLE
  - cmd_ready=1.
  - On a cmd_valid&&cmd_ready handshake, latch base, len and mode, and clear the word counter.
  - If len=0, go to DONE. Otherwise go to LOAD (mode 0) or DUMP_RD (mode 1).
- LOAD
  - ld_ready=1.
  - Each ld_valid&&ld_ready writes ld_data to base+count, then increments count.
  - After word len−1 is accepted, go to DONE.
- DUMP_RD
  - Read array[base+count] into dp_data, then go to DUMP_OUT.
- DUMP_OUT
  - dp_valid=1. dp_data is held stable until dp_valid&&dp_ready.
  - On handshake, increment count. If count=len, go to DONE; otherwise go to DUMP_RD.
- DONE
  - done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE. cpu_stall=busy.
- Address arithmetic
  - base+count is computed modulo 2^ADDR_WIDTH, so 0xFFFF+1 wraps to 0x0000.
  - Addresses ≥ DEPTH are unimplemented: writes are dropped and reads return 0. The same rule applies to the CPU port.
- CPU port
  - Active only when busy=0.
  - With cpu_we=1, cpu_din is written at cpu_addr. With cpu_we=0, cpu_dout ← array[cpu_addr].
  - While busy=1, CPU writes are ignored and cpu_dout holds its last value.
- A command handshake and a CPU write in the same IDLE cycle: the CPU write completes, because busy is still 0 in that cycle.
- Array contents are not cleared by reset.

## Timing
- Reset values: cpu_dout=0, cpu_stall=0, cmd_ready=0 while reset_n=0 (1 in the first cycle after release), ld_ready=0, dp_valid=0, dp_data=0, busy=0, done=0, FSM=IDLE, count=0.
- CPU read latency is 1 cycle: address at edge N gives data valid after edge N+1. A write is visible to a read issued on the following cycle.
- Command latency: busy rises on the edge after the command handshake.
- Load throughput: 1 word/cycle. A len=N load ends with done on cycle N+1 after the command if ld_valid stays high.
- Dump throughput: 1 word per 2 cycles with dp_ready held high. The first dp_valid appears 2 cycles after the command.
- A len=0 command produces done 1 cycle after the handshake, with no stream activity.
- Backpressure: ld_valid low or dp_ready low stalls the FSM indefinitely with no loss or duplication.
- Reset asserted mid-transfer aborts the transfer:
  - No done pulse.
  - Words already written persist.
  - All outputs return to their reset values on that edge.

## Configuration
- MEM_DUMP_EN defined: dump mode is implemented as described above.
- MEM_DUMP_EN undefined:
  - DUMP_RD and DUMP_OUT are not built.
  - A command with cmd_mode=1 is accepted and goes straight to DONE (done pulse, no transfer).
  - dp_valid and dp_data are tied to 0.

## Test plan
- Reset, then CPU write 0xA5 to 0x0010, then read 0x0010 → cpu_dout=0xA5 one cycle after the read address is presented; all outputs were at their reset values during reset.
- Load command base=0x0200, len=4 with stream 0x11,0x22,0x33,0x44 and ld_valid toggling every other cycle → 0x0200–0x0203 contain 0x11–0x44; exactly one done pulse; busy low afterwards.
- Dump command base=0x0200, len=4 with dp_ready stalled for 3 cycles on the second word → dp_data sequence 0x11,0x22,0x33,0x44; each word is held stable during its stall (MEM_DUMP_EN defined). Without the macro → done only, dp_valid never high.
- Load base=0xFFFE, len=4 with DEPTH=0x8000 → 0xFFFE/0xFFFF dropped; data lands at 0x0000 and 0x0001; CPU reads of 0xFFFE return 0.
- During a load, drive a CPU write of 0xEE to 0x0300 → location unchanged, cpu_stall=1. A len=0 command → done 1 cycle after the handshake, with no ld_ready.
- Assert reset_n low after 2 of 4 load words → no done pulse; first 2 words retained; cmd_ready=1 after release.
